// File: rtl/reorder_buffer_if.sv
// Decoder / writeback / commit bundle between the reorder buffer and the core pipeline.
interface reorder_buffer_if #(
    parameter int unsigned ROB_POS_WID = 4
) ();
    logic                   rdy;
    logic                   issue;
    logic [4:0]             issue_rd;
    logic                   issue_is_br;
    logic                   issue_pred_jump;
    logic [ROB_POS_WID-1:0] issue_rob_pos;
    logic                   full;
    logic                   wb_valid;
    logic [ROB_POS_WID-1:0] wb_rob_pos;
    logic [31:0]            wb_val;
    logic                   wb_real_jump;
    logic [31:0]            wb_real_pc;
    logic [ROB_POS_WID-1:0] query_pos;
    logic                   query_ready;
    logic [31:0]            query_val;
    logic                   rob_commit;
    logic [4:0]             rob_commit_rd;
    logic [31:0]            rob_commit_val;
    logic [ROB_POS_WID-1:0] rob_commit_rob_pos;
    logic                   rollback;
    logic [31:0]            rollback_pc;

    modport master (
        output rdy, issue, issue_rd, issue_is_br, issue_pred_jump,
        output wb_valid, wb_rob_pos, wb_val, wb_real_jump, wb_real_pc, query_pos,
        input  issue_rob_pos, full, query_ready, query_val,
        input  rob_commit, rob_commit_rd, rob_commit_val, rob_commit_rob_pos,
        input  rollback, rollback_pc
    );

    modport slave (
        input  rdy, issue, issue_rd, issue_is_br, issue_pred_jump,
        input  wb_valid, wb_rob_pos, wb_val, wb_real_jump, wb_real_pc, query_pos,
        output issue_rob_pos, full, query_ready, query_val,
        output rob_commit, rob_commit_rd, rob_commit_val, rob_commit_rob_pos,
        output rollback, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, in-order commit,
// full flush on a mispredicted branch commit.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE    = 16,
    parameter int unsigned ROB_POS_WID = 4
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave bus
);
    localparam int unsigned CNT_WID = ROB_POS_WID + 1;

    logic [4:0]             r_rd      [ROB_SIZE];
    logic [31:0]            r_val     [ROB_SIZE];
    logic [31:0]            r_real_pc [ROB_SIZE];
    logic [ROB_SIZE-1:0]    r_is_br;
    logic [ROB_SIZE-1:0]    r_pred_jump;
    logic [ROB_SIZE-1:0]    r_real_jump;
    logic [ROB_SIZE-1:0]    r_ready;
    logic [ROB_POS_WID-1:0] r_head;
    logic [ROB_POS_WID-1:0] r_tail;
    logic [CNT_WID-1:0]     r_count;

    logic                   r_commit;
    logic [4:0]             r_commit_rd;
    logic [31:0]            r_commit_val;
    logic [ROB_POS_WID-1:0] r_commit_pos;
    logic                   r_rollback;
    logic [31:0]            r_rollback_pc;

    logic                   w_full;
    logic                   w_issue_ok;
    logic                   w_wb_ok;
    logic                   w_commit;
    logic                   w_mispredict;
    logic                   w_bypass;
    logic [ROB_POS_WID-1:0] w_wb_off;

    // Writeback is accepted only if its slot lies inside the live head..tail window.
    always_comb begin
        w_full       = (r_count == CNT_WID'(ROB_SIZE));
        w_wb_off     = bus.wb_rob_pos - r_head;
        w_issue_ok   = bus.issue && !w_full && !r_rollback;
        w_wb_ok      = bus.wb_valid && !r_rollback && (CNT_WID'(w_wb_off) < r_count);
        w_commit     = (r_count != '0) && r_ready[r_head];
        w_mispredict = w_commit && r_is_br[r_head] && (r_real_jump[r_head] != r_pred_jump[r_head]);
        w_bypass     = bus.wb_valid && (bus.wb_rob_pos == bus.query_pos);
    end

    assign bus.full               = w_full;
    assign bus.issue_rob_pos      = r_tail;
    assign bus.query_ready        = w_bypass ? 1'b1 : r_ready[bus.query_pos];
    assign bus.query_val          = w_bypass ? bus.wb_val : r_val[bus.query_pos];
    assign bus.rob_commit         = r_commit;
    assign bus.rob_commit_rd      = r_commit_rd;
    assign bus.rob_commit_val     = r_commit_val;
    assign bus.rob_commit_rob_pos = r_commit_pos;
    assign bus.rollback           = r_rollback;
    assign bus.rollback_pc        = r_rollback_pc;

    // Pointer, entry and commit-port update; entry payloads need no reset because ready gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_ready       <= '0;
            r_commit      <= 1'b0;
            r_commit_rd   <= '0;
            r_commit_val  <= '0;
            r_commit_pos  <= '0;
            r_rollback    <= 1'b0;
            r_rollback_pc <= '0;
        end else if (!bus.rdy) begin
            r_commit   <= 1'b0;
            r_rollback <= 1'b0;
        end else begin
            r_commit   <= w_commit;
            r_rollback <= w_mispredict;
            if (w_commit) begin
                r_commit_rd  <= r_is_br[r_head] ? 5'd0 : r_rd[r_head];
                r_commit_val <= r_val[r_head];
                r_commit_pos <= r_head;
            end
            if (w_mispredict) begin
                r_rollback_pc <= r_real_pc[r_head];
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                r_ready       <= '0;
            end else begin
                if (w_wb_ok) begin
                    r_ready[bus.wb_rob_pos]     <= 1'b1;
                    r_val[bus.wb_rob_pos]       <= bus.wb_val;
                    r_real_jump[bus.wb_rob_pos] <= bus.wb_real_jump;
                    r_real_pc[bus.wb_rob_pos]   <= bus.wb_real_pc;
                end
                if (w_commit) begin
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + ROB_POS_WID'(1);
                end
                if (w_issue_ok) begin
                    r_rd[r_tail]        <= bus.issue_rd;
                    r_is_br[r_tail]     <= bus.issue_is_br;
                    r_pred_jump[r_tail] <= bus.issue_pred_jump;
                    r_ready[r_tail]     <= 1'b0;
                    r_tail              <= r_tail + ROB_POS_WID'(1);
                end
                r_count <= r_count + CNT_WID'(w_issue_ok) - CNT_WID'(w_commit);
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized run
// against a queue-based model of the buffer.
module tb_reorder_buffer;
    localparam int unsigned ROB_SIZE = 16;
    localparam int unsigned W        = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reorder_buffer_if #(.ROB_POS_WID(W)) bus ();
    reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ROB_POS_WID(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] pos;
        logic [4:0]   rd;
        bit           br;
        bit           pred;
        bit           ready;
        bit           rj;
        logic [31:0]  val;
        logic [31:0]  rpc;
    } ent_t;

    // Model: live entries oldest-first, plus expected registered commit/rollback port.
    ent_t         mq[$];
    logic [W-1:0] m_tail;
    bit           exp_commit, exp_rb;
    logic [4:0]   exp_crd;
    logic [31:0]  exp_cval, exp_rbpc;
    logic [W-1:0] exp_cpos;
    int           errors = 0;
    int           checks = 0;

    task automatic model_edge();
        bit   commit, mis, issue_ok;
        int   wb_idx;
        ent_t e;
        if (rst) begin
            mq.delete(); m_tail = '0;
            exp_commit = 0; exp_rb = 0; exp_crd = '0; exp_cval = '0; exp_cpos = '0; exp_rbpc = '0;
            return;
        end
        if (!bus.rdy) begin
            exp_commit = 0; exp_rb = 0;
            return;
        end
        commit   = (mq.size() > 0) && mq[0].ready;
        mis      = commit && mq[0].br && (mq[0].rj != mq[0].pred);
        issue_ok = bus.issue && (mq.size() < ROB_SIZE) && !exp_rb;
        wb_idx   = -1;
        if (bus.wb_valid && !exp_rb)
            foreach (mq[i]) if (mq[i].pos == bus.wb_rob_pos) wb_idx = i;
        if (commit) begin
            exp_crd  = mq[0].br ? 5'd0 : mq[0].rd;
            exp_cval = mq[0].val;
            exp_cpos = mq[0].pos;
        end
        if (mis) exp_rbpc = mq[0].rpc;
        exp_commit = commit;
        exp_rb     = mis;
        if (mis) begin
            mq.delete(); m_tail = '0;
        end else begin
            if (wb_idx >= 0) begin
                mq[wb_idx].ready = 1; mq[wb_idx].val = bus.wb_val;
                mq[wb_idx].rj = bus.wb_real_jump; mq[wb_idx].rpc = bus.wb_real_pc;
            end
            if (commit) void'(mq.pop_front());
            if (issue_ok) begin
                e.pos = m_tail; e.rd = bus.issue_rd; e.br = bus.issue_is_br; e.pred = bus.issue_pred_jump;
                e.ready = 0; e.rj = 0; e.val = '0; e.rpc = '0;
                mq.push_back(e);
                m_tail = m_tail + 1'b1;
            end
        end
    endtask

    function automatic bit model_query(input logic [W-1:0] q, output bit r, output logic [31:0] v);
        r = 0; v = '0;
        if (bus.wb_valid && bus.wb_rob_pos == q) begin r = 1; v = bus.wb_val; return 1; end
        foreach (mq[i]) if (mq[i].pos == q) begin r = mq[i].ready; v = mq[i].val; return 1; end
        return 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.rdy = 1'b1; bus.issue = 1'b0; bus.issue_rd = '0; bus.issue_is_br = 1'b0;
        bus.issue_pred_jump = 1'b0; bus.wb_valid = 1'b0; bus.wb_rob_pos = '0; bus.wb_val = '0;
        bus.wb_real_jump = 1'b0; bus.wb_real_pc = '0; bus.query_pos = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; cycle(); cycle();
        checks++; if (bus.rob_commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b want 0", bus.rob_commit); end
        checks++; if (bus.rollback !== 1'b0) begin errors++; $display("FAIL reset_rollback: got %b want 0", bus.rollback); end
        checks++; if (bus.rob_commit_rd !== 5'd0 || bus.rob_commit_val !== 32'd0 || bus.rob_commit_rob_pos !== 4'd0)
            begin errors++; $display("FAIL reset_payload: got rd=%0d val=%h pos=%0d want 0", bus.rob_commit_rd, bus.rob_commit_val, bus.rob_commit_rob_pos); end
        checks++; if (bus.rollback_pc !== 32'd0) begin errors++; $display("FAIL reset_rbpc: got %h want 0", bus.rollback_pc); end
        rst = 1'b0; #1;
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.issue_rob_pos !== 4'd0) begin errors++; $display("FAIL reset_tail: got %0d want 0", bus.issue_rob_pos); end
    endtask

    task automatic test_basic_commit();
        do_reset();
        bus.issue = 1'b1; bus.issue_rd = 5'd5; cycle();
        bus.issue = 1'b0; bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'h1234; cycle();
        checks++; if (bus.rob_commit !== 1'b0) begin errors++; $display("FAIL basic_latency: got %b want 0", bus.rob_commit); end
        bus.wb_valid = 1'b0; cycle();
        checks++; if (bus.rob_commit !== 1'b1 || bus.rob_commit_rd !== 5'd5 || bus.rob_commit_val !== 32'h1234 || bus.rob_commit_rob_pos !== 4'd0)
            begin errors++; $display("FAIL basic_commit: got c=%b rd=%0d val=%h pos=%0d want 1/5/1234/0", bus.rob_commit, bus.rob_commit_rd, bus.rob_commit_val, bus.rob_commit_rob_pos); end
        cycle();
        checks++; if (bus.rob_commit !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", bus.rob_commit); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin bus.issue = 1'b1; bus.issue_rd = 5'(i + 1); cycle(); end
        bus.issue = 1'b0; bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'hA0; cycle();
        bus.wb_valid = 1'b0; bus.issue = 1'b1; bus.issue_rd = 5'd16; #1;
        checks++; if (bus.issue_rob_pos !== 4'd15 || bus.full !== 1'b0) begin errors++; $display("FAIL full_pre: got pos=%0d full=%b want 15/0", bus.issue_rob_pos, bus.full); end
        cycle();
        checks++; if (bus.rob_commit !== 1'b1 || bus.rob_commit_rob_pos !== 4'd0) begin errors++; $display("FAIL full_commit_issue: got c=%b pos=%0d want 1/0", bus.rob_commit, bus.rob_commit_rob_pos); end
        checks++; if (bus.issue_rob_pos !== 4'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL full_wrap: got tail=%0d full=%b want 0/0", bus.issue_rob_pos, bus.full); end
        bus.issue_rd = 5'd17; cycle();
        checks++; if (bus.full !== 1'b1 || bus.issue_rob_pos !== 4'd1) begin errors++; $display("FAIL full_set: got full=%b tail=%0d want 1/1", bus.full, bus.issue_rob_pos); end
        bus.issue_rd = 5'd18; cycle();
        checks++; if (bus.full !== 1'b1 || bus.issue_rob_pos !== 4'd1) begin errors++; $display("FAIL full_ignore: got full=%b tail=%0d want 1/1", bus.full, bus.issue_rob_pos); end
        bus.issue = 1'b0;
    endtask

    task automatic test_rollback();
        do_reset();
        bus.issue = 1'b1; bus.issue_rd = 5'd7; bus.issue_is_br = 1'b1; bus.issue_pred_jump = 1'b0; cycle();
        bus.issue_rd = 5'd3; bus.issue_is_br = 1'b0; cycle();
        bus.issue = 1'b0; bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'h55;
        bus.wb_real_jump = 1'b1; bus.wb_real_pc = 32'h80; cycle();
        bus.wb_valid = 1'b0; bus.issue = 1'b1; bus.issue_rd = 5'd9; cycle();
        checks++; if (bus.rollback !== 1'b1 || bus.rollback_pc !== 32'h80) begin errors++; $display("FAIL rb_pulse: got rb=%b pc=%h want 1/80", bus.rollback, bus.rollback_pc); end
        checks++; if (bus.rob_commit !== 1'b1 || bus.rob_commit_rd !== 5'd0) begin errors++; $display("FAIL rb_commit_rd: got c=%b rd=%0d want 1/0", bus.rob_commit, bus.rob_commit_rd); end
        checks++; if (bus.issue_rob_pos !== 4'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL rb_flush: got tail=%0d full=%b want 0/0", bus.issue_rob_pos, bus.full); end
        bus.wb_valid = 1'b1; cycle();
        checks++; if (bus.rollback !== 1'b0 || bus.issue_rob_pos !== 4'd0) begin errors++; $display("FAIL rb_ignore: got rb=%b tail=%0d want 0/0", bus.rollback, bus.issue_rob_pos); end
        bus.wb_valid = 1'b0; cycle();
        checks++; if (bus.issue_rob_pos !== 4'd1) begin errors++; $display("FAIL rb_accept: got tail=%0d want 1", bus.issue_rob_pos); end
        bus.issue = 1'b0;
    endtask

    task automatic test_out_of_order();
        logic [3:0] order [3] = '{4'd2, 4'd0, 4'd1};
        do_reset();
        for (int i = 0; i < 3; i++) begin bus.issue = 1'b1; bus.issue_rd = 5'(i + 1); cycle(); end
        bus.issue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wb_valid = 1'b1; bus.wb_rob_pos = order[i]; bus.wb_val = 32'h100 + 32'(order[i]); cycle();
        end
        bus.wb_valid = 1'b0;
        // The pos-0 commit was registered at the last writeback edge.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cycle();
            checks++; if (bus.rob_commit !== 1'b1 || bus.rob_commit_rob_pos !== 4'(i) || bus.rob_commit_rd !== 5'(i + 1) || bus.rob_commit_val !== 32'h100 + 32'(i))
                begin errors++; $display("FAIL ooo_commit%0d: got c=%b pos=%0d rd=%0d val=%h", i, bus.rob_commit, bus.rob_commit_rob_pos, bus.rob_commit_rd, bus.rob_commit_val); end
        end
    endtask

    task automatic test_query_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin bus.issue = 1'b1; bus.issue_rd = 5'(i); cycle(); end
        bus.issue = 1'b0; bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd3; bus.wb_val = 32'hDEADBEEF; bus.query_pos = 4'd3; #1;
        checks++; if (bus.query_ready !== 1'b1 || bus.query_val !== 32'hDEADBEEF) begin errors++; $display("FAIL query_bypass: got r=%b v=%h want 1/deadbeef", bus.query_ready, bus.query_val); end
        bus.query_pos = 4'd1; #1;
        checks++; if (bus.query_ready !== 1'b0) begin errors++; $display("FAIL query_notready: got %b want 0", bus.query_ready); end
        cycle();
        bus.wb_valid = 1'b0; bus.query_pos = 4'd3; #1;
        checks++; if (bus.query_ready !== 1'b1 || bus.query_val !== 32'hDEADBEEF) begin errors++; $display("FAIL query_stored: got r=%b v=%h want 1/deadbeef", bus.query_ready, bus.query_val); end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        bus.issue = 1'b1; bus.issue_rd = 5'd12; cycle();
        bus.issue = 1'b0; bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'd0; bus.wb_val = 32'h77; cycle();
        bus.wb_valid = 1'b0; bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (bus.rob_commit !== 1'b0) begin errors++; $display("FAIL rdy_hold%0d: got %b want 0", i, bus.rob_commit); end
        end
        bus.rdy = 1'b1; cycle();
        checks++; if (bus.rob_commit !== 1'b1 || bus.rob_commit_rd !== 5'd12 || bus.rob_commit_val !== 32'h77)
            begin errors++; $display("FAIL rdy_release: got c=%b rd=%0d val=%h want 1/12/77", bus.rob_commit, bus.rob_commit_rd, bus.rob_commit_val); end
    endtask

    task automatic test_random();
        bit          kr, r;
        logic [31:0] v;
        int          idx;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst                 = ($urandom_range(299) == 0);
            bus.rdy             = ($urandom_range(9) != 0);
            bus.issue           = ($urandom_range(2) != 0);
            bus.issue_rd        = 5'($urandom);
            bus.issue_is_br     = ($urandom_range(4) == 0);
            bus.issue_pred_jump = 1'($urandom);
            bus.wb_valid        = 1'b0;
            bus.wb_val          = $urandom;
            bus.wb_real_pc      = $urandom;
            bus.wb_real_jump    = 1'($urandom);
            if (mq.size() > 0 && $urandom_range(1) == 1) begin
                idx = $urandom_range(mq.size() - 1);
                bus.wb_valid = 1'b1; bus.wb_rob_pos = mq[idx].pos;
                if (mq[idx].br) bus.wb_real_jump = ($urandom_range(3) == 0) ? !mq[idx].pred : mq[idx].pred;
            end else if ($urandom_range(3) == 0) begin
                bus.wb_valid = 1'b1; bus.wb_rob_pos = 4'($urandom);
            end
            bus.query_pos = 4'($urandom);
            #1;
            checks++; if (bus.full !== (mq.size() == ROB_SIZE)) begin errors++; $display("FAIL rnd_full@%0d: got %b want %b", n, bus.full, mq.size() == ROB_SIZE); end
            checks++; if (bus.issue_rob_pos !== m_tail) begin errors++; $display("FAIL rnd_tail@%0d: got %0d want %0d", n, bus.issue_rob_pos, m_tail); end
            kr = model_query(bus.query_pos, r, v);
            if (kr) begin
                checks++; if (bus.query_ready !== r || (r && bus.query_val !== v))
                    begin errors++; $display("FAIL rnd_query@%0d: got r=%b v=%h want r=%b v=%h", n, bus.query_ready, bus.query_val, r, v); end
            end
            cycle();
            checks++; if (bus.rob_commit !== exp_commit || bus.rollback !== exp_rb)
                begin errors++; $display("FAIL rnd_pulse@%0d: got c=%b rb=%b want c=%b rb=%b", n, bus.rob_commit, bus.rollback, exp_commit, exp_rb); end
            checks++; if (bus.rob_commit_rd !== exp_crd || bus.rob_commit_val !== exp_cval || bus.rob_commit_rob_pos !== exp_cpos || bus.rollback_pc !== exp_rbpc)
                begin errors++; $display("FAIL rnd_payload@%0d: got rd=%0d val=%h pos=%0d pc=%h want rd=%0d val=%h pos=%0d pc=%h", n,
                    bus.rob_commit_rd, bus.rob_commit_val, bus.rob_commit_rob_pos, bus.rollback_pc, exp_crd, exp_cval, exp_cpos, exp_rbpc); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_rollback();
        test_out_of_order();
        test_query_bypass();
        test_rdy_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
